// File: rtl/sha256_pkg.sv
// Constants and types shared between the SHA-256 compression core and the
// message sequencer: IV, round constants, widths and the sequencer state set.
package sha256_pkg;

    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 256;
    localparam int WORD_W   = 32;

    localparam logic [WORD_W-1:0] H0 = 32'h6a09e667;
    localparam logic [WORD_W-1:0] H1 = 32'hbb67ae85;
    localparam logic [WORD_W-1:0] H2 = 32'h3c6ef372;
    localparam logic [WORD_W-1:0] H3 = 32'ha54ff53a;
    localparam logic [WORD_W-1:0] H4 = 32'h510e527f;
    localparam logic [WORD_W-1:0] H5 = 32'h9b05688c;
    localparam logic [WORD_W-1:0] H6 = 32'h1f83d9ab;
    localparam logic [WORD_W-1:0] H7 = 32'h5be0cd19;

    localparam logic [0:63][WORD_W-1:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FILL,
        S_ISSUE,
        S_WAIT,
        S_LENBLK
    } seq_state_e;

endpackage

// File: rtl/sha256_pad_insert.sv
// Masks the bytes of a final message word beyond nbytes and merges the 0x80
// marker right after them; flags when the marker spills into the next word.
module sha256_pad_insert
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [2:0]        nbytes_i,
    output logic [WORD_W-1:0] word_o,
    output logic              marker_overflow_o
);

    logic [WORD_W-1:0] mask;
    logic [WORD_W-1:0] marker;

    always_comb begin
        mask   = '0;
        marker = '0;
        case (nbytes_i)
            3'd0:    marker = 32'h8000_0000;
            3'd1:    begin mask = 32'hFF00_0000; marker = 32'h0080_0000; end
            3'd2:    begin mask = 32'hFFFF_0000; marker = 32'h0000_8000; end
            3'd3:    begin mask = 32'hFFFF_FF00; marker = 32'h0000_0080; end
            default: mask = 32'hFFFF_FFFF;
        endcase
    end

    assign word_o            = (word_i & mask) | marker;
    assign marker_overflow_o = (nbytes_i >= 3'd4);

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Message-level controller for the SHA-256 core: assembles 512-bit blocks from
// a 32-bit word stream, applies length padding, and returns the final digest.
module sha256_msg_sequencer
    import sha256_pkg::*;
#(
    parameter int LEN_W       = 64,
    parameter int INIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_last,
    input  logic [2:0]          s_nbytes,
    output logic                core_init,
    output logic                core_start,
    output logic [BLOCK_W-1:0]  core_block,
    input  logic                core_ready,
    input  logic [DIGEST_W-1:0] core_digest,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic                busy
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    seq_state_e                 state_q, state_d;
    logic [0:15][WORD_W-1:0]    buf_q, buf_d;
    logic [3:0]                 idx_q, idx_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic                       final_q, final_d;
    logic                       pad_q, pad_d;
    logic                       mark_q, mark_d;
    logic [INIT_W-1:0]          icnt_q, icnt_d;
    logic [DIGEST_W-1:0]        digest_q, digest_d;
    logic                       dvalid_q, dvalid_d;

    logic [WORD_W-1:0]          pad_word;
    logic                       mark_ovf;
    logic [2:0]                 nb_eff;
    logic [LEN_W-1:0]           len_acc;
    logic [63:0]                len64_acc, len64_q;
    logic [6:0]                 pos;

    sha256_pad_insert u_pad (
        .word_i            (s_data),
        .nbytes_i          (s_nbytes),
        .word_o            (pad_word),
        .marker_overflow_o (mark_ovf)
    );

    always_comb begin
        nb_eff    = s_last ? s_nbytes : 3'd4;
        len_acc   = len_q + LEN_W'({nb_eff, 3'b000});
        len64_acc = '0;
        len64_acc[LEN_W-1:0] = len_acc;
        len64_q   = '0;
        len64_q[LEN_W-1:0]   = len_q;
        // byte offset of the 0x80 marker within the block
        pos       = {1'b0, idx_q, 2'b00} + 7'(s_nbytes);
    end

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        idx_d    = idx_q;
        len_d    = len_q;
        final_d  = final_q;
        pad_d    = pad_q;
        mark_d   = mark_q;
        icnt_d   = icnt_q;
        digest_d = digest_q;
        dvalid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    state_d = S_INIT;
                    icnt_d  = '0;
                end
            end

            S_INIT: begin
                if (icnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d = S_FILL;
                    idx_d   = '0;
                    len_d   = '0;
                end else begin
                    icnt_d = icnt_q + 1'b1;
                end
            end

            S_FILL: begin
                if (s_valid) begin
                    len_d = len_acc;
                    if (!s_last) begin
                        buf_d[idx_q] = s_data;
                        if (idx_q == 4'd15) begin
                            state_d = S_ISSUE;
                            final_d = 1'b0;
                            pad_d   = 1'b0;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else begin
                        for (int i = 0; i < 16; i++) begin
                            if (4'(i) > idx_q) buf_d[i] = '0;
                        end
                        buf_d[idx_q] = pad_word;
                        // a full last word pushes the marker into the next word
                        if (mark_ovf && idx_q != 4'd15) buf_d[idx_q + 4'd1] = 32'h8000_0000;
                        state_d = S_ISSUE;
                        if (pos <= 7'd55) begin
                            buf_d[14] = len64_acc[63:32];
                            buf_d[15] = len64_acc[31:0];
                            final_d   = 1'b1;
                            pad_d     = 1'b0;
                        end else begin
                            final_d = 1'b0;
                            pad_d   = 1'b1;
                            mark_d  = (pos == 7'd64);
                        end
                    end
                end
            end

            S_ISSUE: state_d = S_WAIT;

            S_WAIT: begin
                if (core_ready) begin
                    if (final_q) begin
                        digest_d = core_digest;
                        dvalid_d = 1'b1;
                        state_d  = S_IDLE;
                    end else if (pad_q) begin
                        state_d = S_LENBLK;
                    end else begin
                        state_d = S_FILL;
                        idx_d   = '0;
                    end
                end
            end

            S_LENBLK: begin
                buf_d = '0;
                if (mark_q) buf_d[0] = 32'h8000_0000;
                buf_d[14] = len64_q[63:32];
                buf_d[15] = len64_q[31:0];
                final_d   = 1'b1;
                pad_d     = 1'b0;
                mark_d    = 1'b0;
                state_d   = S_ISSUE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            buf_q    <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            final_q  <= 1'b0;
            pad_q    <= 1'b0;
            mark_q   <= 1'b0;
            icnt_q   <= '0;
            digest_q <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            final_q  <= final_d;
            pad_q    <= pad_d;
            mark_q   <= mark_d;
            icnt_q   <= icnt_d;
            digest_q <= digest_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign s_ready      = (state_q == S_FILL) & ~rst;
    assign core_start   = (state_q == S_ISSUE) & ~rst;
    assign core_init    = rst | (state_q == S_INIT);
    assign core_block   = buf_q;
    assign digest       = digest_q;
    assign digest_valid = dvalid_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Bench for the message sequencer: behavioural SHA-256 core, scoreboard of
// expected blocks and digests, and one task per scenario.
module tb_sha256_msg_sequencer;
    import sha256_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [31:0]         s_data;
    logic                s_valid, s_ready, s_last;
    logic [2:0]          s_nbytes;
    logic                core_init, core_start, core_ready;
    logic [511:0]        core_block;
    logic [255:0]        core_digest, digest;
    logic                digest_valid, busy;

    int checks = 0;
    int errors = 0;
    int dig_cnt = 0;
    int st_cnt = 0;

    logic [511:0] exp_blk_q[$];
    logic [255:0] exp_dig_q[$];

    localparam logic [255:0] IV_C = {H0, H1, H2, H3, H4, H5, H6, H7};

    always #5 clk = ~clk;

    sha256_msg_sequencer #(.LEN_W(64), .INIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .s_nbytes(s_nbytes),
        .core_init(core_init), .core_start(core_start), .core_block(core_block),
        .core_ready(core_ready), .core_digest(core_digest),
        .digest(digest), .digest_valid(digest_valid), .busy(busy)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Software padding: pushes the expected blocks and returns the digest.
    function automatic logic [255:0] sw_model(input byte unsigned m[$]);
        byte unsigned p[$];
        logic [63:0]  bl;
        logic [511:0] blk;
        logic [255:0] h;
        p  = m;
        bl = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(bl[63 - 8*i -: 8]);
        h = IV_C;
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*bi + j];
            exp_blk_q.push_back(blk);
            h = compress(h, blk);
        end
        return h;
    endfunction

    function automatic void str2q(input string s, output byte unsigned q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endfunction

    // Behavioural core with variable latency
    logic [255:0] chain;
    logic [511:0] blk_l;
    logic         pend;
    int           lat;

    always @(posedge clk) begin
        core_ready <= 1'b0;
        if (core_init) begin
            chain <= IV_C;
            pend  <= 1'b0;
        end else if (core_start) begin
            blk_l <= core_block;
            lat   <= $urandom_range(0, 4);
            pend  <= 1'b1;
        end else if (pend) begin
            if (lat == 0) begin
                core_ready  <= 1'b1;
                core_digest <= compress(chain, blk_l);
                chain       <= compress(chain, blk_l);
                pend        <= 1'b0;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        logic [511:0] eb;
        logic [255:0] ed;
        forever begin
            @(negedge clk);
            if (core_start) begin
                st_cnt++;
                checks++;
                if (exp_blk_q.size() == 0) begin
                    errors++;
                    $display("FAIL block_unexpected got %h", core_block);
                end else begin
                    eb = exp_blk_q.pop_front();
                    if (core_block !== eb) begin
                        errors++;
                        $display("FAIL block got %h exp %h", core_block, eb);
                    end
                end
            end
            if (digest_valid) begin
                dig_cnt++;
                checks++;
                if (exp_dig_q.size() == 0) begin
                    errors++;
                    $display("FAIL digest_unexpected got %h", digest);
                end else begin
                    ed = exp_dig_q.pop_front();
                    if (digest !== ed) begin
                        errors++;
                        $display("FAIL digest got %h exp %h", digest, ed);
                    end
                end
            end
            if ((pend || core_ready) && !rst) begin
                checks++;
                if (s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL s_ready_in_wait got %b exp 0", s_ready);
                end
            end
        end
    end

    task automatic drive_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t = 0;
        s_data = d; s_last = last; s_nbytes = nb; s_valid = 1'b1;
        while (!s_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL s_accept timeout got s_ready=%b exp 1", s_ready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_msg(input byte unsigned m[$], input bit keep);
        int nw, rem;
        logic [31:0] w;
        nw = (m.size() == 0) ? 1 : (m.size() + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            w   = 32'hA5A5_A5A5;
            rem = m.size() - 4*i;
            if (rem > 4) rem = 4;
            for (int j = 0; j < rem; j++) w[31 - 8*j -: 8] = m[4*i + j];
            drive_word(w, i == nw - 1, 3'(rem));
        end
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_nbytes = 3'd0;
        repeat (2) @(negedge clk);
        checks++; if (core_init !== 1'b1) begin errors++; $display("FAIL rst_core_init got %b exp 1", core_init); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %b exp 0", s_ready); end
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rst_core_start got %b exp 0", core_start); end
        checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL rst_digest_valid got %b exp 0", digest_valid); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (digest !== 256'd0) begin errors++; $display("FAIL rst_digest got %h exp 0", digest); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (core_init !== 1'b0) begin errors++; $display("FAIL idle_core_init got %b exp 0", core_init); end
    endtask

    task automatic test_known(input string name, input string msg, input logic [255:0] exp_d, input int nblk);
        byte unsigned m[$];
        logic [255:0] dummy;
        int d0, s0, t;
        str2q(msg, m);
        dummy = sw_model(m);
        exp_dig_q.push_back(exp_d);
        d0 = dig_cnt; s0 = st_cnt;
        send_msg(m, 1'b0);
        t = 0;
        while (dig_cnt < d0 + 1 && t < 3000) begin @(negedge clk); t++; end
        checks++;
        if (dig_cnt != d0 + 1) begin errors++; $display("FAIL %s digest_count got %0d exp %0d", name, dig_cnt - d0, 1); end
        checks++;
        if (st_cnt - s0 != nblk) begin errors++; $display("FAIL %s starts got %0d exp %0d", name, st_cnt - s0, nblk); end
        if (dummy === 256'd0) $display("note: zero model digest for %s", name);
    endtask

    task automatic test_lengths;
        int lens[6] = '{55, 57, 63, 64, 119, 120};
        byte unsigned m[$];
        int d0, t;
        foreach (lens[k]) begin
            m = {};
            for (int i = 0; i < lens[k]; i++) m.push_back(8'((i * 7 + 3 + k) & 8'hFF));
            exp_dig_q.push_back(sw_model(m));
            d0 = dig_cnt;
            send_msg(m, 1'b0);
            t = 0;
            while (dig_cnt < d0 + 1 && t < 3000) begin @(negedge clk); t++; end
            checks++;
            if (dig_cnt != d0 + 1) begin errors++; $display("FAIL len%0d digest_count got %0d exp 1", lens[k], dig_cnt - d0); end
        end
    endtask

    task automatic test_back_to_back;
        byte unsigned m1[$], m2[$];
        int d0, t;
        for (int i = 0; i < 100; i++) m1.push_back(8'($urandom_range(0, 255)));
        str2q("abc", m2);
        exp_dig_q.push_back(sw_model(m1));
        exp_dig_q.push_back(sw_model(m2));
        d0 = dig_cnt;
        send_msg(m1, 1'b1);
        send_msg(m2, 1'b0);
        t = 0;
        while (dig_cnt < d0 + 2 && t < 5000) begin @(negedge clk); t++; end
        checks++;
        if (dig_cnt != d0 + 2) begin errors++; $display("FAIL b2b digest_count got %0d exp 2", dig_cnt - d0); end
    endtask

    task automatic test_reset_mid;
        int d0;
        d0 = dig_cnt;
        drive_word(32'h0102_0304, 1'b0, 3'd4);
        drive_word(32'h0506_0708, 1'b0, 3'd4);
        drive_word(32'h090a_0b0c, 1'b0, 3'd4);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (core_init !== 1'b1) begin errors++; $display("FAIL midrst_core_init got %b exp 1", core_init); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (digest !== 256'd0) begin errors++; $display("FAIL midrst_digest got %h exp 0", digest); end
        repeat (8) @(negedge clk);
        checks++; if (dig_cnt != d0) begin errors++; $display("FAIL midrst_no_digest got %0d exp 0", dig_cnt - d0); end
        test_known("abc_after_rst", "abc",
                   256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad, 1);
    endtask

    initial begin
        test_reset;
        test_known("empty", "",
                   256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855, 1);
        test_known("abc", "abc",
                   256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad, 1);
        test_known("msg56", "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq",
                   256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1, 2);
        test_lengths;
        test_back_to_back;
        test_reset_mid;
        repeat (4) @(negedge clk);
        checks++;
        if (exp_blk_q.size() != 0 || exp_dig_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect got blk=%0d dig=%0d exp 0", exp_blk_q.size(), exp_dig_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sequencer.md
Name: sha256_msg_sequencer

Overview:
Message-level controller for the single-block SHA-256 compression core. It accepts an arbitrary-length byte message as a stream of 32-bit big-endian words, assembles 512-bit blocks, and applies FIPS 180-4 padding with the 64-bit bit-length. It re-initialises the core's chaining state per message, issues blocks through the core's start/ready handshake, and returns the final 256-bit digest.

Parameters:
LEN_W, 64, width of internal bit-length counter (1..64); zero-extended into the 64-bit length field; wraps modulo 2^LEN_W.
INIT_CYCLES, 1, number of cycles core_init is held high in INIT (>=1).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
s_data  in  32  message word, big-endian (byte 0 in [31:24])
s_valid  in  1  s_data valid
s_ready  out  1  sequencer accepts word this cycle (s_valid & s_ready)
s_last  in  1  final word of message
s_nbytes  in  3  valid bytes in the last word, 0..4 (0 only for an empty message); must be 4 when s_last=0
core_init  out  1  high: core must reload IV (integrator drives core rst_n = ~core_init)
core_start  out  1  one-cycle pulse, core_block valid
core_block  out  512  block to compress
core_ready  in  1  core completion pulse; core_digest valid this cycle
core_digest  in  256  core chaining value
digest  out  256  final message digest
digest_valid  out  1  one-cycle pulse, digest valid
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at edge, any state): state=IDLE; s_ready, core_start, digest_valid=0; digest=0; buffer, word_idx and bit_len cleared. core_init=1 during reset cycles. A reset mid-message discards the message with no digest.
- IDLE: s_ready=0. s_valid=1 -> INIT (word not consumed).
- INIT: core_init=1 for INIT_CYCLES cycles, then FILL with word_idx=0, bit_len=0.
- FILL: s_ready=1. On accept: store the word at buffer[word_idx]; bit_len += 8*nbytes (nbytes=4 when not last).
  - Not last, word_idx<15: word_idx++.
  - Not last, word_idx=15: -> ISSUE with final=0, pad_pending=0.
  - Last: bytes past s_nbytes are zeroed. Marker 0x80 is placed at block byte p=4*word_idx+s_nbytes; all later bytes are zeroed.
    - p<=55: words 14..15 = 64-bit bit_len (including this word); -> ISSUE with final=1.
    - 56<=p<=63: -> ISSUE with final=0, pad_pending=1, marker_pending=0.
    - p=64: -> ISSUE with final=0, pad_pending=1, marker_pending=1.
- ISSUE: core_start=1 for exactly one cycle; core_block = buffer, word 0 in [511:480]. -> WAIT.
- WAIT: s_ready=0; core_start=0; wait for core_ready.
  - final=1: digest<=core_digest, digest_valid=1 next cycle, -> IDLE.
  - pad_pending=1: -> LENBLK.
  - Otherwise: -> FILL, word_idx=0.
- LENBLK (one cycle): buffer = zeros with 0x80 in byte 0 if marker_pending; words 14..15 = bit_len; final=1; -> ISSUE.
- core_ready outside WAIT is ignored. core_block holds the last issued value until the next buffer write.
- Each block costs exactly 2 controller cycles (ISSUE plus the transition cycle out of WAIT) plus core latency. One message is processed at a time; s_ready stays low from WAIT until the next FILL.

Decomposition:
- Shared package sha256_pkg holds:
  - IV constants H0..H7 and the K[0:63] table, both shared with the core.
  - Localparams BLOCK_W=512, DIGEST_W=256, WORD_W=32.
  - The sequencer state enum (IDLE, INIT, FILL, ISSUE, WAIT, LENBLK).
- One combinational sub-module, sha256_pad_insert:
  - Inputs: word, nbytes.
  - Outputs: masked word, 0x80 marker merged when nbytes<4, and a marker_overflow flag when nbytes=4.

Test Plan:
- Empty message: single word with s_last=1, s_nbytes=0 -> one core_start. Block is 0x80000000 followed by zeros, length 0. digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- "abc": word 0x61626300, s_last=1, s_nbytes=3 -> block word0=0x61626380, word15=0x00000018. digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two core_start pulses, the second via LENBLK with marker_pending=0 and length 0x1c0. digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- 64-byte message ending with s_nbytes=4 at word 15 -> second block word0=0x80000000, word15=0x00000200. digest matches the software model.
- Backpressure and reset: s_valid held high throughout -> s_ready=0 in every WAIT cycle and no words are lost. Then assert rst in the middle of FILL -> next cycle IDLE, no digest_valid, core_init=1. A following "abc" message yields the correct digest.
